// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshakes.
// The ripple-carry chain is split into STAGES registered CHUNK-bit slices.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? 1'b1 : cin;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // IW: operand bits still pending on entry; OW: bits forwarded (only the sign bit out of the last stage)
        localparam int IW = WIDTH - k * CHUNK;
        localparam int OW = (k == STAGES - 1) ? 1 : WIDTH - (k + 1) * CHUNK;
        localparam int RW = (k + 1) * CHUNK;

        logic [IW-1:0]  op_a;
        logic [IW-1:0]  op_b;
        logic           c_in;
        logic           v_in;
        logic [CHUNK:0] chunk_sum;
        logic [OW-1:0]  rem_a_d, rem_a_q;
        logic [OW-1:0]  rem_b_d, rem_b_q;
        logic [RW-1:0]  res_d, res_q;
        logic           carry_d, carry_q;
        logic           valid_d, valid_q;

        if (k == 0) begin : g_head
            always_comb begin
                op_a  = a;
                op_b  = b_eff;
                c_in  = c0;
                v_in  = in_valid;
                res_d = res_q;
                if (adv) begin
                    res_d = chunk_sum[CHUNK-1:0];
                end
            end
        end else begin : g_body
            always_comb begin
                op_a  = g_stage[k-1].rem_a_q;
                op_b  = g_stage[k-1].rem_b_q;
                c_in  = g_stage[k-1].carry_q;
                v_in  = g_stage[k-1].valid_q;
                res_d = res_q;
                if (adv) begin
                    res_d = {chunk_sum[CHUNK-1:0], g_stage[k-1].res_q};
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            always_comb begin
                rem_a_d = rem_a_q;
                rem_b_d = rem_b_q;
                if (adv) begin
                    rem_a_d = op_a[IW-1];
                    rem_b_d = op_b[IW-1];
                end
            end
        end else begin : g_mid
            always_comb begin
                rem_a_d = rem_a_q;
                rem_b_d = rem_b_q;
                if (adv) begin
                    rem_a_d = op_a[IW-1:CHUNK];
                    rem_b_d = op_b[IW-1:CHUNK];
                end
            end
        end

        always_comb begin
            chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
            carry_d   = carry_q;
            valid_d   = valid_q;
            if (adv) begin
                carry_d = chunk_sum[CHUNK];
                valid_d = v_in;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem_a_q <= '0;
                rem_b_q <= '0;
                res_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                rem_a_q <= rem_a_d;
                rem_b_q <= rem_b_d;
                res_q   <= res_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end
    end

    // The whole pipeline advances or holds as one; bubbles are not squeezed out
    always_comb begin
        sum       = g_stage[STAGES-1].res_q;
        cout      = g_stage[STAGES-1].carry_q;
        out_valid = g_stage[STAGES-1].valid_q;
        ovf       = (g_stage[STAGES-1].rem_a_q == g_stage[STAGES-1].rem_b_q) &&
                    (sum[WIDTH-1] != g_stage[STAGES-1].rem_a_q[0]);
        adv       = !out_valid || out_ready;
        in_ready  = adv;
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub across several WIDTH/STAGES configurations.
// Each configuration has its own driver, backpressure generator and output monitor.
module tb_pipelined_addsub;

    localparam int NCFG    = 5;
    localparam int TIMEOUT = 20000;

    logic            clk = 1'b0;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    logic [NCFG-1:0] done_vec;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string what, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", what, got, req);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 8 : (g == 3) ? 32 : 64;
        localparam int S = (g == 0) ? 4  : (g == 1) ? 1 : (g == 2) ? 8 : (g == 3) ? 4  : 8;
        localparam logic [W-1:0] ONES = '1;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;

        logic [W+1:0] exp_q[$];
        int           acc_q[$];
        int           st_q[$];
        int           stall_cnt = 0;
        int           rmode = 0;
        bit           fin = 1'b0;
        bit           fin_checked = 1'b0;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        assign done_vec[g] = fin_checked;

        // Reference: {cout, ovf, sum} from unsigned/signed arithmetic on the whole operands
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input logic sb);
            logic [W:0]   total;
            logic [W+1:0] sx, sy, sres;
            logic [W-1:0] s;
            logic         c, o;
            sx = {x[W-1], x[W-1], x};
            sy = {y[W-1], y[W-1], y};
            if (sb) begin
                s    = x - y;
                c    = (x >= y);
                sres = sx - sy;
            end else begin
                total = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
                s     = total[W-1:0];
                c     = total[W];
                sres  = sx + sy + {{(W+1){1'b0}}, ci};
            end
            o = !((sres[W+1] == sres[W]) && (sres[W] == sres[W-1]));
            return {c, o, s};
        endfunction

        function automatic logic [W-1:0] rnd();
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       return ONES;
                1:       return ONES >> 1;
                2:       return ~(ONES >> 1);
                3:       return '0;
                default: return r[W-1:0];
            endcase
        endfunction

        task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic sb);
            a        = x;
            b        = y;
            cin      = ci;
            sub      = sb;
            in_valid = 1'b1;
            for (int t = 0; t < 1000; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    exp_q.push_back(model(x, y, ci, sb));
                    acc_q.push_back(cyc + 1);
                    st_q.push_back(stall_cnt);
                    @(posedge clk);
                    #1;
                    return;
                end
            end
        endtask

        // Backpressure: always ready in mode 0, otherwise random with a 5-cycle low stretch
        initial begin
            int rcnt;
            rcnt      = 0;
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                if (rmode == 0) begin
                    out_ready = 1'b1;
                    rcnt      = 0;
                end else begin
                    rcnt++;
                    if ((rcnt % 40) >= 5 && (rcnt % 40) < 10) out_ready = 1'b0;
                    else out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end

        initial begin
            rst_n    = 1'b0;
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            cin      = 1'b0;
            sub      = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            applyStimulus(W'(16'h00FF), W'(16'h0001), 1'b0, 1'b0);
            applyStimulus(ONES, '0, 1'b1, 1'b0);
            applyStimulus(ONES >> 1, W'(1), 1'b0, 1'b0);
            applyStimulus(W'(5), W'(7), 1'b1, 1'b1);
            applyStimulus(~(ONES >> 1), W'(1), 1'b0, 1'b1);

            rmode = 1;
            repeat (20) applyStimulus(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

            // Asynchronous reset with beats still in flight; they must never appear
            rmode = 0;
            repeat (3) applyStimulus(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
            in_valid = 1'b0;
            #2 rst_n = 1'b0;
            exp_q.delete();
            acc_q.delete();
            st_q.delete();
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
            applyStimulus(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

            rmode = 1;
            repeat (200) applyStimulus(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

            in_valid = 1'b0;
            rmode    = 0;
            for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
            repeat (2) @(posedge clk);
            fin = 1'b1;
        end

        initial begin
            logic [W+1:0] exp_v;
            logic [W+1:0] prev_v;
            bit           prev_hold;
            int           acc;
            int           st;
            string        tag;
            prev_hold = 1'b0;
            prev_v    = '0;
            tag       = $sformatf("W%0d/S%0d", W, S);
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    checkOutput({tag, " reset_outputs"}, 128'({out_valid, cout, ovf, sum}), 128'(0));
                    prev_hold = 1'b0;
                    stall_cnt = 0;
                end else begin
                    checkOutput({tag, " in_ready"}, 128'(in_ready), 128'(!out_valid || out_ready));
                    if (prev_hold)
                        checkOutput({tag, " stall_hold"}, 128'({out_valid, cout, ovf, sum}),
                                    128'({1'b1, prev_v}));
                    if (out_valid && out_ready) begin
                        checkOutput({tag, " beat_expected"}, 128'(exp_q.size() != 0), 128'(1));
                        if (exp_q.size() != 0) begin
                            exp_v = exp_q.pop_front();
                            acc   = acc_q.pop_front();
                            st    = st_q.pop_front();
                            checkOutput({tag, " result"}, 128'({cout, ovf, sum}), 128'(exp_v));
                            checkOutput({tag, " latency"}, 128'(cyc - acc), 128'(S - 1 + stall_cnt - st));
                        end
                    end
                    if (!in_ready) stall_cnt++;
                    prev_hold = out_valid && !out_ready;
                    prev_v    = {cout, ovf, sum};
                    if (fin && !fin_checked) begin
                        checkOutput({tag, " drained"}, 128'(exp_q.size()), 128'(0));
                        fin_checked = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if ((&done_vec) || cyc >= TIMEOUT) begin
                checkOutput("all_configs_done", 128'(done_vec), 128'({NCFG{1'b1}}));
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule
